// File: rtl/al4s3b_wb_pkg.sv
// Shared constants for the Wishbone client aperture arbiter: client map, FSM states, timeout read value.
// No logic; latency and backpressure are defined by the modules that import it.
package al4s3b_wb_pkg;

    localparam logic [16:0] FAB_REG_BASE = 17'h00000;
    localparam logic [16:0] UART0_BASE   = 17'h01000;
    localparam logic [16:0] QL_RSVD_BASE = 17'h03000;

    localparam int CLIENT_FAB_REG = 0;
    localparam int CLIENT_UART0   = 1;
    localparam int CLIENT_QL_RSVD = 2;
    localparam int NUM_CLIENTS    = 3;

    localparam logic [31:0] DEFAULT_READ_VALUE = 32'hBAD_FAB_AC;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_DONE = 2'd2
    } wb_state_t;

endpackage

// File: rtl/wb_timeout_counter.sv
// Wait-cycle counter: synchronous clear, count enable, combinational terminal flag.
// Counts on the cycle after enable; no backpressure, the owner stops enabling at terminal.
module wb_timeout_counter #(
    parameter int               WIDTH    = 3,
    parameter logic [WIDTH-1:0] TERMINAL = '1
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic en,
    output logic terminal
);

    logic [WIDTH-1:0] count;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count <= '0;
        end else if (clr) begin
            count <= '0;
        end else if (en) begin
            count <= count + 1'b1;
        end
    end

    assign terminal = (count == TERMINAL);

endmodule

// File: rtl/wb_aperture_arbiter.sv
// Decodes each Wishbone access to one client, strobes its CYC and returns one registered ack/data.
// Ack 1 cycle after client ack (2 min, 1 access per 3 cycles); unanswered accesses time out.
module wb_aperture_arbiter #(
    parameter int              APERWIDTH                = 17,
    parameter int              APERSIZE                 = 10,
    parameter logic [16:0]     FPGA_REG_BASE_ADDRESS    = al4s3b_wb_pkg::FAB_REG_BASE,
    parameter logic [16:0]     UART0_BASE_ADDRESS       = al4s3b_wb_pkg::UART0_BASE,
    parameter logic [16:0]     QL_RESERVED_BASE_ADDRESS = al4s3b_wb_pkg::QL_RSVD_BASE,
    parameter logic [31:0]     DEFAULT_READ_VALUE       = al4s3b_wb_pkg::DEFAULT_READ_VALUE,
    parameter int              DEFAULT_CNTR_WIDTH       = 3,
    parameter int              DEFAULT_CNTR_TIMEOUT     = 7
) (
    input  logic                 WB_CLK,
    input  logic                 WB_RST,
    input  logic [APERWIDTH-1:0] WBs_ADR_i,
    input  logic                 WBs_CYC_i,
    input  logic                 WBs_STB_i,
    output logic [31:0]          WBs_RD_DAT_o,
    output logic                 WBs_ACK_o,
    output logic [2:0]           client_CYC_o,
    input  logic [2:0]           client_ACK_i,
    input  logic [95:0]          client_RD_DAT_i,
    output logic                 timeout_o,
    output logic [7:0]           timeout_cnt_o
);

    import al4s3b_wb_pkg::*;

    localparam int DEC_LSB = APERSIZE + 2;

    wb_state_t   state;
    logic [2:0]  sel_dec;
    logic        ack_hit;
    logic [31:0] sel_dat;
    logic        cnt_clr;
    logic        cnt_en;
    logic        cnt_terminal;
    logic        unused_adr_lsb;

    assign unused_adr_lsb = ^WBs_ADR_i[DEC_LSB-1:0];

    always_comb begin
        sel_dec = '0;
        sel_dec[CLIENT_FAB_REG] = (WBs_ADR_i[APERWIDTH-1:DEC_LSB] == FPGA_REG_BASE_ADDRESS[APERWIDTH-1:DEC_LSB]);
        sel_dec[CLIENT_UART0]   = (WBs_ADR_i[APERWIDTH-1:DEC_LSB] == UART0_BASE_ADDRESS[APERWIDTH-1:DEC_LSB]);
        sel_dec[CLIENT_QL_RSVD] = (WBs_ADR_i[APERWIDTH-1:DEC_LSB] == QL_RESERVED_BASE_ADDRESS[APERWIDTH-1:DEC_LSB]);
    end

    // client_CYC_o holds the registered one-hot select for the whole WAIT phase.
    assign ack_hit = |(client_ACK_i & client_CYC_o);

    always_comb begin
        sel_dat = '0;
        for (int n = 0; n < NUM_CLIENTS; n++) begin
            if (client_CYC_o[n]) begin
                sel_dat = sel_dat | client_RD_DAT_i[32*n +: 32];
            end
        end
    end

    assign cnt_clr = (state == ST_IDLE) || ((state == ST_WAIT) && !WBs_CYC_i);
    assign cnt_en  = (state == ST_WAIT) && WBs_CYC_i && !ack_hit && !cnt_terminal;

    wb_timeout_counter #(
        .WIDTH    (DEFAULT_CNTR_WIDTH),
        .TERMINAL (DEFAULT_CNTR_WIDTH'(DEFAULT_CNTR_TIMEOUT))
    ) u_timeout_counter (
        .clk      (WB_CLK),
        .rst      (WB_RST),
        .clr      (cnt_clr),
        .en       (cnt_en),
        .terminal (cnt_terminal)
    );

    always_ff @(posedge WB_CLK or posedge WB_RST) begin
        if (WB_RST) begin
            state         <= ST_IDLE;
            WBs_ACK_o     <= 1'b0;
            WBs_RD_DAT_o  <= '0;
            client_CYC_o  <= '0;
            timeout_o     <= 1'b0;
            timeout_cnt_o <= '0;
        end else begin
            WBs_ACK_o <= 1'b0;
            timeout_o <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (WBs_CYC_i && WBs_STB_i) begin
                        client_CYC_o <= sel_dec;
                        state        <= ST_WAIT;
                    end
                end
                ST_WAIT: begin
                    if (!WBs_CYC_i) begin
                        client_CYC_o <= '0;
                        state        <= ST_IDLE;
                    end else if (ack_hit) begin
                        WBs_ACK_o    <= 1'b1;
                        WBs_RD_DAT_o <= sel_dat;
                        client_CYC_o <= '0;
                        state        <= ST_DONE;
                    end else if (cnt_terminal) begin
                        WBs_ACK_o    <= 1'b1;
                        WBs_RD_DAT_o <= DEFAULT_READ_VALUE;
                        timeout_o    <= 1'b1;
                        if (timeout_cnt_o != 8'hFF) begin
                            timeout_cnt_o <= timeout_cnt_o + 8'd1;
                        end
                        client_CYC_o <= '0;
                        state        <= ST_DONE;
                    end
                end
                ST_DONE: begin
                    state <= ST_IDLE;
                end
                default: begin
                    client_CYC_o <= '0;
                    state        <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_wb_aperture_arbiter.sv
// Directed bench for wb_aperture_arbiter: normal reads, timeouts, ack priority, abort, reset, saturation.
module tb_wb_aperture_arbiter;

    logic        WB_CLK;
    logic        WB_RST;
    logic [16:0] WBs_ADR_i;
    logic        WBs_CYC_i;
    logic        WBs_STB_i;
    logic [31:0] WBs_RD_DAT_o;
    logic        WBs_ACK_o;
    logic [2:0]  client_CYC_o;
    logic [2:0]  client_ACK_i;
    logic [95:0] client_RD_DAT_i;
    logic        timeout_o;
    logic [7:0]  timeout_cnt_o;

    int n_assert = 0;
    int n_fail   = 0;

    wb_aperture_arbiter dut (
        .WB_CLK          (WB_CLK),
        .WB_RST          (WB_RST),
        .WBs_ADR_i       (WBs_ADR_i),
        .WBs_CYC_i       (WBs_CYC_i),
        .WBs_STB_i       (WBs_STB_i),
        .WBs_RD_DAT_o    (WBs_RD_DAT_o),
        .WBs_ACK_o       (WBs_ACK_o),
        .client_CYC_o    (client_CYC_o),
        .client_ACK_i    (client_ACK_i),
        .client_RD_DAT_i (client_RD_DAT_i),
        .timeout_o       (timeout_o),
        .timeout_cnt_o   (timeout_cnt_o)
    );

    initial WB_CLK = 1'b0;
    always #5 WB_CLK = ~WB_CLK;

    task automatic tick();
        @(posedge WB_CLK);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int  waited;
        logic got;

        WB_RST          = 1'b1;
        WBs_ADR_i       = '0;
        WBs_CYC_i       = 1'b0;
        WBs_STB_i       = 1'b0;
        client_ACK_i    = '0;
        client_RD_DAT_i = {32'hCAFE_0003, 32'h0000_0041, 32'h1234_5678};
        tick();
        chk("rst_ack",  WBs_ACK_o,     0);
        chk("rst_dat",  WBs_RD_DAT_o,  0);
        chk("rst_ccyc", client_CYC_o,  0);
        chk("rst_tout", timeout_o,     0);
        chk("rst_tcnt", timeout_cnt_o, 0);
        tick();
        WB_RST = 1'b0;
        tick();

        // UART0 read, client acks in cycle 2
        WBs_ADR_i = 17'h01004; WBs_CYC_i = 1'b1; WBs_STB_i = 1'b1;
        tick();
        chk("uart_ccyc_c1", client_CYC_o, 3'b010);
        chk("uart_ack_c1",  WBs_ACK_o, 0);
        tick();
        chk("uart_ack_c2",  WBs_ACK_o, 0);
        client_ACK_i = 3'b010;
        tick();
        chk("uart_ack_c3",  WBs_ACK_o, 1);
        chk("uart_dat_c3",  WBs_RD_DAT_o, 32'h0000_0041);
        chk("uart_tout_c3", timeout_o, 0);
        chk("uart_ccyc_c3", client_CYC_o, 0);
        client_ACK_i = '0; WBs_CYC_i = 1'b0; WBs_STB_i = 1'b0;
        tick();
        chk("uart_ack_c4",  WBs_ACK_o, 0);
        chk("uart_hold_c4", WBs_RD_DAT_o, 32'h0000_0041);

        // Unmapped read times out at cycle 9
        WBs_ADR_i = 17'h02000; WBs_CYC_i = 1'b1; WBs_STB_i = 1'b1;
        for (int c = 1; c <= 8; c++) begin
            tick();
            chk("unm_ccyc", client_CYC_o, 0);
            chk("unm_ack",  WBs_ACK_o, 0);
        end
        tick();
        chk("unm_ack_c9",  WBs_ACK_o, 1);
        chk("unm_dat_c9",  WBs_RD_DAT_o, 32'hBADFABAC);
        chk("unm_tout_c9", timeout_o, 1);
        chk("unm_tcnt_c9", timeout_cnt_o, 1);
        WBs_CYC_i = 1'b0; WBs_STB_i = 1'b0;
        tick();
        chk("unm_tout_c10", timeout_o, 0);
        chk("unm_ack_c10",  WBs_ACK_o, 0);
        chk("unm_hold_c10", WBs_RD_DAT_o, 32'hBADFABAC);

        // FAB_REG selected, spurious UART0 ack, FAB_REG ack coincides with terminal count
        WBs_ADR_i = 17'h00010; WBs_CYC_i = 1'b1; WBs_STB_i = 1'b1;
        for (int c = 1; c <= 8; c++) begin
            tick();
            chk("fab_ack_wait", WBs_ACK_o, 0);
            if (c == 1) chk("fab_ccyc_c1", client_CYC_o, 3'b001);
            if (c == 2) client_ACK_i = 3'b010;
            if (c == 8) client_ACK_i = 3'b011;
        end
        tick();
        chk("fab_ack_c9",  WBs_ACK_o, 1);
        chk("fab_dat_c9",  WBs_RD_DAT_o, 32'h1234_5678);
        chk("fab_tout_c9", timeout_o, 0);
        chk("fab_tcnt_c9", timeout_cnt_o, 1);
        client_ACK_i = '0; WBs_CYC_i = 1'b0; WBs_STB_i = 1'b0;
        tick();

        // Abort in WAIT cycle 3, then a normal QL_RESERVED access
        WBs_ADR_i = 17'h03008; WBs_CYC_i = 1'b1; WBs_STB_i = 1'b1;
        tick();
        chk("abt_ccyc_c1", client_CYC_o, 3'b100);
        tick();
        tick();
        WBs_CYC_i = 1'b0; WBs_STB_i = 1'b0;
        for (int c = 4; c <= 14; c++) begin
            tick();
            chk("abt_ack",  WBs_ACK_o, 0);
            chk("abt_ccyc", client_CYC_o, 0);
            chk("abt_tout", timeout_o, 0);
        end
        WBs_CYC_i = 1'b1; WBs_STB_i = 1'b1;
        tick();
        chk("ql_ccyc_c1", client_CYC_o, 3'b100);
        client_ACK_i = 3'b100;
        tick();
        chk("ql_ack_c2", WBs_ACK_o, 1);
        chk("ql_dat_c2", WBs_RD_DAT_o, 32'hCAFE_0003);
        client_ACK_i = '0; WBs_CYC_i = 1'b0; WBs_STB_i = 1'b0;
        tick();

        // Reset pulsed during WAIT
        WBs_ADR_i = 17'h01004; WBs_CYC_i = 1'b1; WBs_STB_i = 1'b1;
        tick();
        tick();
        chk("rstw_ccyc_pre", client_CYC_o, 3'b010);
        #2 WB_RST = 1'b1;
        #1;
        chk("rstw_ccyc", client_CYC_o,  0);
        chk("rstw_ack",  WBs_ACK_o,     0);
        chk("rstw_dat",  WBs_RD_DAT_o,  0);
        chk("rstw_tout", timeout_o,     0);
        chk("rstw_tcnt", timeout_cnt_o, 0);
        WBs_CYC_i = 1'b0; WBs_STB_i = 1'b0;
        client_ACK_i = 3'b010;
        tick();
        WB_RST = 1'b0;
        for (int c = 0; c < 10; c++) begin
            tick();
            chk("rstw_post_ack", WBs_ACK_o, 0);
        end
        client_ACK_i = '0;

        // 300 unmapped accesses saturate the timeout counter
        WBs_ADR_i = 17'h1F000;
        for (int a = 0; a < 300; a++) begin
            WBs_CYC_i = 1'b1; WBs_STB_i = 1'b1;
            got = 1'b0;
            waited = 0;
            for (int w = 0; w < 20 && !got; w++) begin
                tick();
                waited++;
                if (WBs_ACK_o) got = 1'b1;
            end
            chk("sat_ack", WBs_ACK_o, 1);
            if (a == 0)   chk("sat_latency", waited, 9);
            if (a == 253) chk("sat_tcnt_254", timeout_cnt_o, 254);
            WBs_CYC_i = 1'b0; WBs_STB_i = 1'b0;
            tick();
        end
        chk("sat_tcnt_255", timeout_cnt_o, 255);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule

// File: doc/wb_aperture_arbiter.md
# wb_aperture_arbiter

Wishbone client-side sequencer between the AHB-to-FPGA bridge (WBs_* from the cell macro) and the FPGA's register clients: FPGA register block, UART0, QL-reserved block. It decodes each access to one client, sequences that client's cycle strobe, and returns a single registered acknowledge and read-data word. Accesses to unmapped space, and accesses a client never acknowledges, are terminated by a timeout with DEFAULT_READ_VALUE, so the bridge never hangs.

## Interface
- APERWIDTH, 17, Wishbone byte-address width
- APERSIZE, 10, client aperture in words; decode uses ADR[APERWIDTH-1:APERSIZE+2]
- FPGA_REG_BASE_ADDRESS, 17'h00000, client 0 base
- UART0_BASE_ADDRESS, 17'h01000, client 1 base
- QL_RESERVED_BASE_ADDRESS, 17'h03000, client 2 base
- DEFAULT_READ_VALUE, 32'hBAD_FAB_AC, read data returned on timeout
- DEFAULT_CNTR_WIDTH, 3, timeout counter width
- DEFAULT_CNTR_TIMEOUT, 7, last wait count before forced ack; must fit DEFAULT_CNTR_WIDTH
- WB_CLK  in  1  Wishbone clock; all logic rising-edge
- WB_RST  in  1  reset, asynchronous, active-high
- WBs_ADR_i  in  APERWIDTH  byte address
- WBs_CYC_i  in  1  bus cycle
- WBs_STB_i  in  1  transfer strobe
- WBs_RD_DAT_o  out  32  read data to bridge, registered
- WBs_ACK_o  out  1  one-cycle acknowledge to bridge, registered
- client_CYC_o  out  3  per-client cycle select (bit 0 FAB_REG, bit 1 UART0, bit 2 QL_RESERVED)
- client_ACK_i  in  3  per-client acknowledge
- client_RD_DAT_i  in  96  client n read data at [32n+31:32n]
- timeout_o  out  1  one-cycle pulse when an access is timeout-terminated
- timeout_cnt_o  out  8  saturating count of timeout terminations

WBs_WE, WBs_BYTE_STB and WBs_WR_DAT go directly to the clients, not through this block.

## Operation
- States: IDLE, WAIT, DONE.
- **IDLE**
  - On WBs_CYC_i & WBs_STB_i: decode the address and register a one-hot select (all zero if unmapped); clear the counter; go to WAIT.
  - Decode: client n matches when ADR[APERWIDTH-1:APERSIZE+2] == BASE_n[APERWIDTH-1:APERSIZE+2].
- **WAIT**
  - client_CYC_o = registered select.
  - If WBs_CYC_i drops (abort): go to IDLE. No ack; the counter is not incremented.
  - Else if the selected client's ACK is high: register WBs_ACK_o=1 and WBs_RD_DAT_o = that client's data; go to DONE.
  - Else if count == DEFAULT_CNTR_TIMEOUT: register WBs_ACK_o=1, WBs_RD_DAT_o=DEFAULT_READ_VALUE and timeout_o=1; increment timeout_cnt_o (saturate at 255); go to DONE.
  - Else: count+1.
- **DONE**
  - client_CYC_o=0 for one cycle; then go to IDLE unconditionally. This gap lets the bridge drop STB.
- Boundary cases:
  - ACKs from non-selected clients are ignored.
  - Client ACK in the same cycle as count==TIMEOUT: the client wins; no timeout.
  - Unmapped address: no client_CYC_o bit is ever set; the access always times out.
  - A timed-out write is acknowledged and its data is discarded by the clients.
  - WBs_RD_DAT_o holds its value between accesses.

## Timing
- Reset values: state IDLE, WBs_ACK_o=0, WBs_RD_DAT_o=0, client_CYC_o=0, timeout_o=0, timeout_cnt_o=0, counter=0. Reset asserted mid-access aborts it with no ack.
- Request seen in IDLE at cycle 0: client_CYC_o high from cycle 1.
- Client ACK at cycle k (k≥1): WBs_ACK_o and data at k+1. Minimum latency is 2 cycles, at 1 access per 3 cycles.
- Timeout: WAIT cycles 1..T+1 (T=DEFAULT_CNTR_TIMEOUT); forced ACK at cycle T+2 (9 for T=7).
- WBs_ACK_o and timeout_o are exactly one cycle wide.

## Structure
- Package al4s3b_wb_pkg holds:
  - the three base-address constants and client index constants (CLIENT_FAB_REG=0, CLIENT_UART0=1, CLIENT_QL_RSVD=2);
  - the state enum;
  - DEFAULT_READ_VALUE.
- Sub-module wb_timeout_counter: clear, enable, terminal-count flag, parameterised by width and terminal value.
- The address decode stays inline.

## Test plan
- Read at 17'h01004; UART0 acks 2 cycles after its CYC with 32'h0000_0041: client_CYC_o=3'b010, WBs_ACK_o at cycle 3 with RD_DAT 32'h0000_0041, no timeout.
- Read at 17'h02000 (unmapped): client_CYC_o stays 0; ACK at cycle 9 with 32'hBAD_FAB_AC; timeout_o pulses; timeout_cnt_o=1.
- FAB_REG selected, UART0 acks spuriously, FAB_REG acks at count 7 → only the FAB_REG data is returned; timeout_o=0.
- WBs_CYC_i dropped at cycle 3 of WAIT → IDLE, no ACK, counter cleared; the next access completes normally.
- WB_RST pulsed during WAIT → all outputs 0 immediately; no ACK after release.
- 300 unmapped accesses → timeout_cnt_o saturates at 255.
